// File: rtl/usb_pkg.sv
// Shared USB transaction-layer types: request codes, PIDs, packet record and FSM states.
package usb_pkg;

   typedef enum logic [2:0] {
      MSG_NONE     = 3'd0,
      MSG_IN_TOK   = 3'd1,
      MSG_OUT_TOK  = 3'd2,
      MSG_OUT_DATA = 3'd3,
      MSG_IN_DATA  = 3'd4
   } msg_e;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;

   typedef struct packed {
      logic [3:0]  pid;
      logic [6:0]  addr;
      logic [3:0]  endp;
      logic [63:0] data;
   } usb_pkt_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_TOKEN,
      ST_TX_DATA,
      ST_WAIT_HS,
      ST_RX_WAIT,
      ST_TX_HS,
      ST_DONE
   } fsm_state_e;

   // Codes 5-7 are not requests and must leave the engine idle.
   function automatic logic is_request(input logic [2:0] code);
      return (code >= MSG_IN_TOK) && (code <= MSG_IN_DATA);
   endfunction

endpackage

// File: rtl/usb_resp_timer.sv
// Response-wait timer: loadable/clearable up-counter that saturates and flags expiry at LIMIT.
module usb_resp_timer #(
   parameter int LIMIT = 255,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         rst_L,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst_L || clr) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != W'(LIMIT))) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign expired = en && (count_reg == W'(LIMIT));

endmodule

// File: rtl/usb_protocol_fsm.sv
// USB transaction engine: turns one sequencer request into token/data/handshake packet
// exchanges, retrying data messages on NAK, corruption or response timeout.
module usb_protocol_fsm
   import usb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'd5,
   parameter logic [3:0] DEV_ENDP    = 4'd4,
   parameter int         TIMEOUT_CYC = 255,
   parameter int         MAX_TRIES   = 8
) (
   input  logic        clk,
   input  logic        rst_L,
   input  logic [2:0]  msg_type,
   input  logic [63:0] rw_dout,
   output logic        protocol_free,
   output logic        timeout,
   output logic [63:0] rw_din,
   output logic        tx_start,
   output logic [3:0]  tx_pid,
   output logic [6:0]  tx_addr,
   output logic [3:0]  tx_endp,
   output logic [63:0] tx_data,
   input  logic        tx_done,
   input  logic        rx_valid,
   input  logic [3:0]  rx_pid,
   input  logic [63:0] rx_data,
   input  logic        rx_ok
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   fsm_state_e       state_reg;
   logic [TRY_W-1:0] tries_reg;
   logic [TRY_W-1:0] tries_inc;
   logic             last_try;
   logic [63:0]      req_data_reg;
   logic             hs_ack_reg;
   logic             wait_active;
   logic             timer_clr;
   logic             expired;

   assign tx_addr   = DEV_ADDR;
   assign tx_endp   = DEV_ENDP;
   assign tries_inc = tries_reg + TRY_W'(1);
   assign last_try  = (tries_inc == TRY_W'(MAX_TRIES));

   // The timer restarts on every entry to a wait state and after each expiry,
   // so a retried RX_WAIT gets a full window again.
   assign wait_active = (state_reg == ST_WAIT_HS) || (state_reg == ST_RX_WAIT);
   assign timer_clr   = !wait_active || expired;

   usb_resp_timer #(
      .LIMIT (TIMEOUT_CYC),
      .W     (TMR_W)
   ) u_resp_timer (
      .clk      (clk),
      .rst_L    (rst_L),
      .clr      (timer_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (wait_active),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         state_reg     <= ST_IDLE;
         tries_reg     <= '0;
         req_data_reg  <= '0;
         hs_ack_reg    <= 1'b0;
         protocol_free <= 1'b1;
         timeout       <= 1'b0;
         rw_din        <= '0;
         tx_start      <= 1'b0;
         tx_pid        <= '0;
         tx_data       <= '0;
      end else begin
         tx_start <= 1'b0;
         timeout  <= 1'b0;
         unique case (state_reg)
            ST_IDLE, ST_DONE: begin
               protocol_free <= 1'b1;
               state_reg     <= ST_IDLE;
               if (is_request(msg_type)) begin
                  protocol_free <= 1'b0;
                  tries_reg     <= '0;
                  req_data_reg  <= rw_dout;
                  case (msg_type)
                     MSG_IN_TOK: begin
                        state_reg <= ST_TX_TOKEN;
                        tx_start  <= 1'b1;
                        tx_pid    <= PID_IN;
                     end
                     MSG_OUT_TOK: begin
                        state_reg <= ST_TX_TOKEN;
                        tx_start  <= 1'b1;
                        tx_pid    <= PID_OUT;
                     end
                     MSG_OUT_DATA: begin
                        state_reg <= ST_TX_DATA;
                        tx_start  <= 1'b1;
                        tx_pid    <= PID_DATA0;
                        tx_data   <= rw_dout;
                     end
                     default: state_reg <= ST_RX_WAIT;
                  endcase
               end
            end
            ST_TX_TOKEN: begin
               if (tx_done) begin
                  state_reg     <= ST_DONE;
                  protocol_free <= 1'b1;
               end
            end
            ST_TX_DATA: begin
               if (tx_done) state_reg <= ST_WAIT_HS;
            end
            ST_WAIT_HS: begin
               // A packet arriving in the expiry cycle is judged on its contents.
               if (rx_valid && rx_ok && (rx_pid == PID_ACK)) begin
                  state_reg     <= ST_DONE;
                  protocol_free <= 1'b1;
               end else if (rx_valid || expired) begin
                  if (last_try) begin
                     state_reg     <= ST_DONE;
                     protocol_free <= 1'b1;
                     timeout       <= 1'b1;
                  end else begin
                     tries_reg <= tries_inc;
                     state_reg <= ST_TX_DATA;
                     tx_start  <= 1'b1;
                     tx_pid    <= PID_DATA0;
                     tx_data   <= req_data_reg;
                  end
               end
            end
            ST_RX_WAIT: begin
               if (rx_valid) begin
                  state_reg <= ST_TX_HS;
                  tx_start  <= 1'b1;
                  if (rx_ok && (rx_pid == PID_DATA0)) begin
                     rw_din     <= rx_data;
                     hs_ack_reg <= 1'b1;
                     tx_pid     <= PID_ACK;
                  end else begin
                     hs_ack_reg <= 1'b0;
                     tx_pid     <= PID_NAK;
                  end
               end else if (expired) begin
                  if (last_try) begin
                     state_reg     <= ST_DONE;
                     protocol_free <= 1'b1;
                     timeout       <= 1'b1;
                  end else begin
                     tries_reg <= tries_inc;
                  end
               end
            end
            ST_TX_HS: begin
               if (tx_done) begin
                  if (hs_ack_reg) begin
                     state_reg     <= ST_DONE;
                     protocol_free <= 1'b1;
                  end else if (last_try) begin
                     state_reg     <= ST_DONE;
                     protocol_free <= 1'b1;
                     timeout       <= 1'b1;
                  end else begin
                     tries_reg <= tries_inc;
                     state_reg <= ST_RX_WAIT;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// Directed bench for usb_protocol_fsm: plays sequencer, encoder and decoder by hand.
`timescale 1ns/1ps
module tb_usb_protocol_fsm;

   localparam logic [2:0] C_NONE     = 3'd0;
   localparam logic [2:0] C_IN_TOK   = 3'd1;
   localparam logic [2:0] C_OUT_TOK  = 3'd2;
   localparam logic [2:0] C_OUT_DATA = 3'd3;
   localparam logic [2:0] C_IN_DATA  = 3'd4;
   localparam logic [3:0] P_OUT   = 4'b0001;
   localparam logic [3:0] P_IN    = 4'b1001;
   localparam logic [3:0] P_DATA0 = 4'b0011;
   localparam logic [3:0] P_ACK   = 4'b0010;
   localparam logic [3:0] P_NAK   = 4'b1010;
   // tx_done cycle -> 256 WAIT_HS cycles (count 0..255) -> next tx_start
   localparam int RETRY_GAP = 257;

   logic        clk = 1'b0;
   logic        rst_L;
   logic [2:0]  msg_type;
   logic [63:0] rw_dout;
   logic        protocol_free;
   logic        timeout;
   logic [63:0] rw_din;
   logic        tx_start;
   logic [3:0]  tx_pid;
   logic [6:0]  tx_addr;
   logic [3:0]  tx_endp;
   logic [63:0] tx_data;
   logic        tx_done;
   logic        rx_valid;
   logic [3:0]  rx_pid;
   logic [63:0] rx_data;
   logic        rx_ok;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int starts      = 0;
   int timeouts    = 0;
   logic [3:0]  start_pids[$];
   logic [63:0] start_data[$];

   usb_protocol_fsm dut (
      .clk           (clk),
      .rst_L         (rst_L),
      .msg_type      (msg_type),
      .rw_dout       (rw_dout),
      .protocol_free (protocol_free),
      .timeout       (timeout),
      .rw_din        (rw_din),
      .tx_start      (tx_start),
      .tx_pid        (tx_pid),
      .tx_addr       (tx_addr),
      .tx_endp       (tx_endp),
      .tx_data       (tx_data),
      .tx_done       (tx_done),
      .rx_valid      (rx_valid),
      .rx_pid        (rx_pid),
      .rx_data       (rx_data),
      .rx_ok         (rx_ok)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         starts <= starts + 1;
         start_pids.push_back(tx_pid);
         start_data.push_back(tx_data);
      end
      if (timeout === 1'b1) timeouts <= timeouts + 1;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic request(input logic [2:0] code, input logic [63:0] data);
      msg_type = code;
      rw_dout  = data;
      @(negedge clk);
      msg_type = C_NONE;
   endtask

   task automatic pulse_tx_done();
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic pulse_rx(input logic [3:0] pid, input logic [63:0] data, input logic ok);
      rx_valid = 1'b1;
      rx_pid   = pid;
      rx_data  = data;
      rx_ok    = ok;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_ok    = 1'b0;
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_L = 1'b0; msg_type = C_NONE; rw_dout = '0; tx_done = 1'b0;
      rx_valid = 1'b0; rx_pid = '0; rx_data = '0; rx_ok = 1'b0;
      tick(2);
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL reset_free: got %b want 1", protocol_free); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      vectors++; if (rw_din !== 64'h0) begin miscompares++; $display("FAIL reset_rw_din: got %h want 0", rw_din); end
      rst_L = 1'b1;
      tick(1);
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL reset_idle_free: got %b want 1", protocol_free); end
      $display("[tb] reset done");
   endtask

   task automatic test_out_tok();
      int base;
      base = starts;
      request(C_OUT_TOK, 64'h0);
      vectors++; if (protocol_free !== 1'b0) begin miscompares++; $display("FAIL outtok_busy: got %b want 0", protocol_free); end
      vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL outtok_start: got %b want 1", tx_start); end
      vectors++; if (tx_pid !== P_OUT) begin miscompares++; $display("FAIL outtok_pid: got %b want %b", tx_pid, P_OUT); end
      vectors++; if (tx_addr !== 7'd5) begin miscompares++; $display("FAIL outtok_addr: got %0d want 5", tx_addr); end
      vectors++; if (tx_endp !== 4'd4) begin miscompares++; $display("FAIL outtok_endp: got %0d want 4", tx_endp); end
      // a request while busy must be ignored
      msg_type = C_OUT_DATA;
      tick(29);
      msg_type = C_NONE;
      vectors++; if (protocol_free !== 1'b0) begin miscompares++; $display("FAIL outtok_wait_busy: got %b want 0", protocol_free); end
      pulse_tx_done();
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL outtok_done_free: got %b want 1", protocol_free); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL outtok_timeout: got %b want 0", timeout); end
      tick(2);
      vectors++; if (starts - base !== 1) begin miscompares++; $display("FAIL outtok_starts: got %0d want 1", starts - base); end
      $display("[tb] OUT_TOK transaction done");
   endtask

   task automatic test_out_data_nak();
      int base, qb;
      bit ok;
      base = starts;
      qb   = start_pids.size();
      request(C_OUT_DATA, 64'hDEAD_BEEF_0123_4567);
      for (int k = 0; k < 3; k++) begin
         wait_start(20, ok);
         vectors++; if (!ok) begin miscompares++; $display("FAIL nak_send%0d: got no tx_start want tx_start", k); end
         tick(2);
         pulse_tx_done();
         tick(3);
         pulse_rx((k < 2) ? P_NAK : P_ACK, 64'h0, 1'b1);
      end
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL nak_done_free: got %b want 1", protocol_free); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL nak_timeout: got %b want 0", timeout); end
      tick(2);
      vectors++; if (starts - base !== 3) begin miscompares++; $display("FAIL nak_starts: got %0d want 3", starts - base); end
      for (int k = 0; k < 3; k++) begin
         if (start_pids.size() > qb + k) begin
            vectors++; if (start_pids[qb+k] !== P_DATA0) begin miscompares++; $display("FAIL nak_pid%0d: got %b want %b", k, start_pids[qb+k], P_DATA0); end
            vectors++; if (start_data[qb+k] !== 64'hDEAD_BEEF_0123_4567) begin miscompares++; $display("FAIL nak_data%0d: got %h want deadbeef01234567", k, start_data[qb+k]); end
         end
      end
      $display("[tb] OUT_DATA NAK,NAK,ACK transaction done");
   endtask

   task automatic test_out_data_timeout();
      int base, tbase, done_cyc;
      bit ok, found;
      base     = starts;
      tbase    = timeouts;
      done_cyc = 0;
      request(C_OUT_DATA, 64'h0F0F_F0F0_AAAA_5555);
      for (int k = 0; k < 8; k++) begin
         wait_start(300, ok);
         vectors++; if (!ok) begin miscompares++; $display("FAIL to_send%0d: got no tx_start want tx_start", k); end
         if (k > 0) begin
            vectors++; if (cyc - done_cyc !== RETRY_GAP) begin miscompares++; $display("FAIL to_gap%0d: got %0d want %0d", k, cyc - done_cyc, RETRY_GAP); end
         end
         tick(1);
         done_cyc = cyc;
         pulse_tx_done();
      end
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (protocol_free === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick(1);
      end
      vectors++; if (!found) begin miscompares++; $display("FAIL to_complete: got busy want protocol_free"); end
      vectors++; if (cyc - done_cyc !== RETRY_GAP) begin miscompares++; $display("FAIL to_final_gap: got %0d want %0d", cyc - done_cyc, RETRY_GAP); end
      vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_strobe: got %b want 1", timeout); end
      tick(1);
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_strobe_len: got %b want 0", timeout); end
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL to_idle: got %b want 1", protocol_free); end
      tick(3);
      vectors++; if (starts - base !== 8) begin miscompares++; $display("FAIL to_sends: got %0d want 8", starts - base); end
      vectors++; if (timeouts - tbase !== 1) begin miscompares++; $display("FAIL to_count: got %0d want 1", timeouts - tbase); end
      $display("[tb] OUT_DATA silent-device transaction done");
   endtask

   task automatic test_in_data();
      int tbase;
      tbase = timeouts;
      request(C_IN_DATA, 64'h0);
      vectors++; if (protocol_free !== 1'b0) begin miscompares++; $display("FAIL in_busy: got %b want 0", protocol_free); end
      vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL in_no_start: got %b want 0", tx_start); end
      tick(2);
      pulse_rx(P_DATA0, 64'hFFFF_0000_FFFF_0000, 1'b0);
      vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL in_nak_start: got %b want 1", tx_start); end
      vectors++; if (tx_pid !== P_NAK) begin miscompares++; $display("FAIL in_nak_pid: got %b want %b", tx_pid, P_NAK); end
      tick(1);
      pulse_tx_done();
      vectors++; if (rw_din !== 64'h0) begin miscompares++; $display("FAIL in_bad_ignored: got %h want 0", rw_din); end
      tick(2);
      pulse_rx(P_DATA0, 64'h1122_3344_5566_7788, 1'b1);
      vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL in_ack_start: got %b want 1", tx_start); end
      vectors++; if (tx_pid !== P_ACK) begin miscompares++; $display("FAIL in_ack_pid: got %b want %b", tx_pid, P_ACK); end
      vectors++; if (rw_din !== 64'h1122_3344_5566_7788) begin miscompares++; $display("FAIL in_rw_din: got %h want 1122334455667788", rw_din); end
      tick(1);
      pulse_tx_done();
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL in_done_free: got %b want 1", protocol_free); end
      tick(2);
      vectors++; if (timeouts - tbase !== 0) begin miscompares++; $display("FAIL in_timeout: got %0d want 0", timeouts - tbase); end
      $display("[tb] IN_DATA corrupt-then-good transaction done");
   endtask

   task automatic test_reset_mid();
      int base, tbase;
      base  = starts;
      tbase = timeouts;
      request(C_OUT_DATA, 64'hA5A5_A5A5_5A5A_5A5A);
      tick(1);
      pulse_tx_done();
      tick(5);
      rst_L = 1'b0;
      tick(1);
      rst_L = 1'b1;
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL mid_free: got %b want 1", protocol_free); end
      vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL mid_start: got %b want 0", tx_start); end
      vectors++; if (rw_din !== 64'h0) begin miscompares++; $display("FAIL mid_rw_din: got %h want 0", rw_din); end
      tick(300);
      vectors++; if (starts - base !== 1) begin miscompares++; $display("FAIL mid_no_resend: got %0d want 1", starts - base); end
      vectors++; if (timeouts - tbase !== 0) begin miscompares++; $display("FAIL mid_no_timeout: got %0d want 0", timeouts - tbase); end
      request(C_IN_TOK, 64'h0);
      vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL mid_intok_start: got %b want 1", tx_start); end
      vectors++; if (tx_pid !== P_IN) begin miscompares++; $display("FAIL mid_intok_pid: got %b want %b", tx_pid, P_IN); end
      // tokens wait for tx_done indefinitely
      tick(299);
      vectors++; if (protocol_free !== 1'b0) begin miscompares++; $display("FAIL mid_intok_wait: got %b want 0", protocol_free); end
      pulse_tx_done();
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL mid_intok_done: got %b want 1", protocol_free); end
      tick(2);
      vectors++; if (timeouts - tbase !== 0) begin miscompares++; $display("FAIL mid_intok_timeout: got %0d want 0", timeouts - tbase); end
      $display("[tb] reset-in-WAIT_HS then IN_TOK transaction done");
   endtask

   task automatic test_back_to_back();
      int base;
      request(C_OUT_DATA, 64'h0123_4567_89AB_CDEF);
      vectors++; if (tx_data !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL b2b_tx_data: got %h want 0123456789abcdef", tx_data); end
      tick(1);
      pulse_tx_done();
      tick(2);
      pulse_rx(P_ACK, 64'h0, 1'b1);
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL b2b_done_free: got %b want 1", protocol_free); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout: got %b want 0", timeout); end
      request(C_IN_TOK, 64'h0);
      vectors++; if (protocol_free !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got %b want 0", protocol_free); end
      vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL b2b_start: got %b want 1", tx_start); end
      vectors++; if (tx_pid !== P_IN) begin miscompares++; $display("FAIL b2b_pid: got %b want %b", tx_pid, P_IN); end
      tick(1);
      pulse_tx_done();
      vectors++; if (protocol_free !== 1'b1) begin miscompares++; $display("FAIL b2b_intok_done: got %b want 1", protocol_free); end
      tick(1);
      base = starts;
      msg_type = 3'd6;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         vectors++; if (protocol_free !== 1'b1 || tx_start !== 1'b0) begin miscompares++; $display("FAIL unknown_code%0d: got free=%b start=%b want free=1 start=0", i, protocol_free, tx_start); end
      end
      msg_type = C_NONE;
      tick(2);
      vectors++; if (starts - base !== 0) begin miscompares++; $display("FAIL unknown_starts: got %0d want 0", starts - base); end
      $display("[tb] back-to-back and unknown-code transactions done");
   endtask

   initial begin
      test_reset();
      test_out_tok();
      test_out_data_nak();
      test_out_data_timeout();
      test_in_data();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion want completion before 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/usb_protocol_fsm.md
Name: usb_protocol_fsm

Overview:
- Transaction-layer engine between the read/write sequencer and the USB packet encoder/decoder.
- Accepts one message request (token, outbound data, inbound data) on the `protocol_free` handshake.
- Builds the packet request and runs the handshake exchange with ACK/NAK/timeout retry.
- Returns inbound payload, a done indication (`protocol_free` re-asserted) and a failure strobe (`timeout`).

Parameters:
- DEV_ADDR, 7'd5, device address placed in every token.
- DEV_ENDP, 4'd4, endpoint placed in every token.
- TIMEOUT_CYC, 255, cycles to wait for a response packet before counting a failed attempt.
- MAX_TRIES, 8, total attempts per data message before giving up.

Ports:
- clk  in  1  clock.
- rst_L  in  1  synchronous active-low reset; one clock, sampled on posedge clk only.
- msg_type  in  3  request code: NONE=0, IN_TOK=1, OUT_TOK=2, OUT_DATA=3, IN_DATA=4.
- rw_dout  in  64  payload for OUT_DATA; sampled with the request.
- protocol_free  out  1  idle / ready for a request; also marks completion.
- timeout  out  1  1-cycle strobe: data message failed after MAX_TRIES.
- rw_din  out  64  last good inbound payload; held until the next IN_DATA completes.
- tx_start  out  1  1-cycle strobe to encoder.
- tx_pid  out  4  PID: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, ACK=4'b0010, NAK=4'b1010.
- tx_addr  out  7  token address (DEV_ADDR).
- tx_endp  out  4  token endpoint (DEV_ENDP).
- tx_data  out  64  DATA0 payload.
- tx_done  in  1  encoder finished sending the packet (1-cycle pulse).
- rx_valid  in  1  decoder delivered a packet (1-cycle pulse).
- rx_pid  in  4  received PID.
- rx_data  in  64  received payload.
- rx_ok  in  1  CRC/PID-check passed; qualifies rx_valid.

Behaviour:
- Reset (rst_L=0 at posedge):
  - state=IDLE, protocol_free=1, timeout=0, tx_start=0, rw_din=0, counters=0.
  - Reset mid-transaction abandons it; no strobes are emitted.
- Request acceptance: in IDLE with protocol_free=1 and msg_type!=NONE at a posedge.
  - Latch msg_type and rw_dout.
  - protocol_free goes 0 the next cycle.
  - Requests while protocol_free=0 are ignored.
  - Unknown codes (5-7) are ignored and the block stays in IDLE.
- IN_TOK / OUT_TOK:
  - TX_TOKEN: tx_start pulses in the first cycle of the state, with PID IN/OUT.
  - Wait tx_done -> DONE. No retry, never times out.
- OUT_DATA:
  - TX_DATA: pulse tx_start with DATA0 and the latched payload; on tx_done -> WAIT_HS, clear the timer.
  - WAIT_HS outcomes:
    - rx_valid & rx_ok & rx_pid==ACK -> DONE (success).
    - NAK, bad packet (rx_ok=0), any other PID, or timer reaching TIMEOUT_CYC: tries+1.
    - If tries==MAX_TRIES -> DONE with failure, else -> TX_DATA (resend).
- IN_DATA:
  - RX_WAIT: clear the timer and wait for rx_valid.
  - Good DATA0 (rx_ok=1): rw_din<=rx_data, then TX_HS sending ACK; on tx_done -> DONE success.
  - Corrupt packet (rx_ok=0): TX_HS sending NAK; on tx_done tries+1, then retry RX_WAIT or fail.
  - Timer expiry: tries+1, then retry or fail. No handshake is sent on expiry.
- DONE (1 cycle):
  - protocol_free=1; timeout=1 only on failure.
  - A new request is accepted in this same cycle.
  - The next state is IDLE, or the accepted request's first state.
- Timer:
  - Counts only in WAIT_HS/RX_WAIT.
  - Expiry is the cycle the count equals TIMEOUT_CYC.
  - rx_valid in the expiry cycle takes priority over expiry.
- Simultaneous events:
  - rx_valid during TX_* states is ignored.
  - tx_done outside TX_* states is ignored.
- tries is cleared on request accept; width is clog2(MAX_TRIES+1).
- tx_addr/tx_endp are constant; tx_data is valid while tx_start is high.

Decomposition:
- Package usb_pkg: msg_type codes (enum, 3-bit), PID constants, and packet-type typedef, shared with the sequencer and the encoder/decoder.
- Sub-module usb_resp_timer: loadable/clearable counter with an `expired` output, reused by other response waits.

Test Plan:
- OUT_TOK accepted; tx_done after 30 cycles -> tx_pid=0001, addr 5/endp 4, protocol_free high 1 cycle after tx_done, timeout=0.
- OUT_DATA rw_dout=64'hDEAD_BEEF_0123_4567; decoder returns NAK twice then ACK -> three DATA0 sends with identical payload, success, timeout=0.
- OUT_DATA; decoder silent -> 8 sends, each spaced by 255-cycle timer, timeout strobe exactly once with protocol_free.
- IN_DATA; first packet rx_ok=0, second rx_data=64'h1122_3344_5566_7788 ok -> NAK then ACK sent, rw_din=1122...7788, timeout=0.
- rst_L low for 1 cycle during WAIT_HS -> next cycle protocol_free=1, no tx_start, no timeout; new IN_TOK accepted normally.
- Back-to-back: IN_TOK request presented in the DONE cycle of a prior OUT_DATA -> accepted with no idle gap; msg_type=6 in IDLE -> no activity.
